// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution datapath: default geometry,
// sequencer state encoding and the kernel packing helper used by the array.
package conv_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_IMG_W      = 224;
  localparam int unsigned DEF_IMG_H      = 224;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CLEAR  = 3'd1;
  localparam state_t ST_LOAD   = 3'd2;
  localparam state_t ST_FILL   = 3'd3;
  localparam state_t ST_STREAM = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  // LSB position of kernel tap (row, col) inside a 9*dw packed weight vector.
  function automatic int unsigned w_idx(input int unsigned row,
                                        input int unsigned col,
                                        input int unsigned dw);
    return (row * 3 + col) * dw;
  endfunction

endpackage

// File: rtl/conv_line_buffer_2row.sv
// Two-row line buffer: combinational read of rows y-2/y-1 at column x,
// then on write the column shifts up (top<=mid, mid<=pixel).
module conv_line_buffer_2row #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 224
) (
  input  logic                       clk,
  input  logic [$clog2(IMG_W)-1:0]   i_x,
  input  logic                       i_we,
  input  logic [DATA_WIDTH-1:0]      i_pix,
  output logic [DATA_WIDTH-1:0]      o_top,
  output logic [DATA_WIDTH-1:0]      o_mid
);

  logic [DATA_WIDTH-1:0] r_top [IMG_W];
  logic [DATA_WIDTH-1:0] r_mid [IMG_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_top[i_x] <= r_mid[i_x];
      r_mid[i_x] <= i_pix;
    end
  end

  assign o_top = r_top[i_x];
  assign o_mid = r_mid[i_x];

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the 3x3 systolic array: clear, kernel load, then raster
// to vertical-column conversion. Optional starvation counter: CONV_SEQ_PERF_EN.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned IMG_W      = DEF_IMG_W,
  parameter int unsigned IMG_H      = DEF_IMG_H
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [9*DATA_WIDTH-1:0]   weights_in,
  input  logic                      pix_valid,
  input  logic [DATA_WIDTH-1:0]     pix_data,
  output logic                      pix_ready,
  output logic                      arr_rst,
  output logic                      load_weight,
  output logic [9*DATA_WIDTH-1:0]   filter_weights,
  output logic                      col,
  output logic [3*DATA_WIDTH-1:0]   input_col,
  output logic                      busy,
  output logic                      done
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]               perf_starve
`endif
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_FILL_LAST = YW'(1);

  state_t                  r_state;
  state_t                  w_next;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic                    r_pix_ready;
  logic                    r_arr_rst;
  logic                    r_load_weight;
  logic [9*DATA_WIDTH-1:0] r_filter_weights;
  logic                    r_col;
  logic [3*DATA_WIDTH-1:0] r_input_col;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_acc;
  logic                    w_x_last;
  logic                    w_start_ok;
  logic [DATA_WIDTH-1:0]   w_lb_top;
  logic [DATA_WIDTH-1:0]   w_lb_mid;

  assign w_acc      = pix_valid & r_pix_ready;
  assign w_x_last   = (r_x == X_LAST);
  assign w_start_ok = (r_state == ST_IDLE) & start & ~abort;

  conv_line_buffer_2row #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W)
  ) u_line_buffer (
    .clk   (clk),
    .i_x   (r_x),
    .i_we  (w_acc),
    .i_pix (pix_data),
    .o_top (w_lb_top),
    .o_mid (w_lb_mid)
  );

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) w_next = ST_CLEAR;
        ST_CLEAR:  w_next = ST_LOAD;
        ST_LOAD:   w_next = ST_FILL;
        ST_FILL:   if (w_acc && w_x_last && r_y == Y_FILL_LAST) w_next = ST_STREAM;
        ST_STREAM: if (w_acc && w_x_last && r_y == Y_LAST) w_next = ST_DONE;
        ST_DONE:   w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_x              <= '0;
      r_y              <= '0;
      r_pix_ready      <= 1'b0;
      r_arr_rst        <= 1'b0;
      r_load_weight    <= 1'b0;
      r_filter_weights <= '0;
      r_col            <= 1'b0;
      r_input_col      <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_pix_ready   <= (w_next == ST_FILL) || (w_next == ST_STREAM);
      r_arr_rst     <= (w_next == ST_CLEAR) || abort;
      r_load_weight <= (w_next == ST_LOAD);
      r_busy        <= (w_next != ST_IDLE);
      r_done        <= (w_next == ST_DONE);
      r_col         <= 1'b0;

      if (w_start_ok) r_filter_weights <= weights_in;

      if (abort) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_acc) begin
        if (r_state == ST_STREAM) begin
          r_col       <= 1'b1;
          r_input_col <= {w_lb_top, w_lb_mid, pix_data};
        end
        if (w_x_last) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

  assign pix_ready      = r_pix_ready;
  assign arr_rst        = r_arr_rst;
  assign load_weight    = r_load_weight;
  assign filter_weights = r_filter_weights;
  assign col            = r_col;
  assign input_col      = r_input_col;
  assign busy           = r_busy;
  assign done           = r_done;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] r_perf_starve;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_starve <= '0;
    end else if (w_start_ok) begin
      r_perf_starve <= '0;
    end else if ((r_state == ST_FILL || r_state == ST_STREAM) && !pix_valid &&
                 r_perf_starve != '1) begin
      r_perf_starve <= r_perf_starve + 32'd1;
    end
  end

  assign perf_starve = r_perf_starve;
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer on a 5x4 frame with pixels 0..19.
module tb_conv_frame_sequencer;

  localparam logic [71:0] W1 = 72'h09_08_07_06_05_04_03_02_01;
  localparam logic [71:0] W2 = 72'hA1_A2_A3_A4_A5_A6_A7_A8_A9;

  logic        clk = 1'b0;
  logic        rst, start, abort, pix_valid;
  logic [71:0] weights_in;
  logic [7:0]  pix_data;
  logic        pix_ready, arr_rst, load_weight, col, busy, done;
  logic [71:0] filter_weights;
  logic [23:0] input_col;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] perf_starve;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    int          trig;
    logic [23:0] col;
  } colvec_t;
  colvec_t tbl [10];

  conv_frame_sequencer #(
    .DATA_WIDTH (8),
    .IMG_W      (5),
    .IMG_H      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .weights_in     (weights_in),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .arr_rst        (arr_rst),
    .load_weight    (load_weight),
    .filter_weights (filter_weights),
    .col            (col),
    .input_col      (input_col),
    .busy           (busy),
    .done           (done)
`ifdef CONV_SEQ_PERF_EN
    ,
    .perf_starve    (perf_starve)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic begin_frame(input logic [71:0] w);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    weights_in = w;
    @(negedge clk);
    start = 1'b0;
    chk("clear_arr_rst", arr_rst, 1);
    chk("clear_busy", busy, 1);
    @(negedge clk);
    chk("load_arr_rst_pulse", arr_rst, 0);
    chk("load_weight", load_weight, 1);
    chk("filter_weights", filter_weights, w);
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: three bubbles in FILL
  task automatic run_pixels(input int mode, input bit start_mid,
                            output int ncols, output int ndone, output int nerr);
    int p = 0, gap = 0, prev_idx = -1;
    bit prev_acc = 0, fin = 0, seen_done = 0, issued = 0, v;
    ncols = 0; ndone = 0; nerr = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (col !== (prev_acc && prev_idx >= 10)) nerr++;
      if (col === 1'b1) begin
        if (ncols < 10) begin
          chk($sformatf("col%0d", ncols), input_col, tbl[ncols].col);
          if (tbl[ncols].trig != prev_idx) nerr++;
        end else begin
          nerr++;
        end
        ncols++;
      end
      if (done === 1'b1) begin
        ndone++;
        seen_done = 1;
        chk("done_ready_low", pix_ready, 0);
`ifdef CONV_SEQ_PERF_EN
        if (mode == 2) chk("perf_starve", perf_starve, 3);
`endif
      end
      if (seen_done && busy === 1'b0) fin = 1;
      if (start_mid && p == 12 && !issued) begin
        start = 1'b1;
        weights_in = W2;
        issued = 1;
      end
      pix_data = p[7:0];
      case (mode)
        1: v = (p < 20) && cyc[0];
        2: if (p == 3 && gap < 3) begin v = 0; gap++; end else v = (p < 20);
        default: v = (p < 20);
      endcase
      pix_valid = v;
      prev_acc = v && (pix_ready === 1'b1);
      if (prev_acc) begin
        prev_idx = p;
        p++;
      end
    end
    if (!fin) chk("frame_timeout", 0, 1);
    pix_valid = 1'b0;
  endtask

  task automatic frame_checks(input string tag, input int ncols, input int ndone, input int nerr);
    chk({tag, "_ncols"}, ncols, 10);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_col_timing"}, nerr, 0);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int nc, nd, ne;
    tbl[0] = '{10, 24'h00_05_0A};
    tbl[1] = '{11, 24'h01_06_0B};
    tbl[2] = '{12, 24'h02_07_0C};
    tbl[3] = '{13, 24'h03_08_0D};
    tbl[4] = '{14, 24'h04_09_0E};
    tbl[5] = '{15, 24'h05_0A_0F};
    tbl[6] = '{16, 24'h06_0B_10};
    tbl[7] = '{17, 24'h07_0C_11};
    tbl[8] = '{18, 24'h08_0D_12};
    tbl[9] = '{19, 24'h09_0E_13};

    rst = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b0;
    pix_data = '0; weights_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_arr_rst", arr_rst, 0);
    chk("rst_load_weight", load_weight, 0);
    chk("rst_filter_weights", filter_weights, 0);
    chk("rst_col", col, 0);
    chk("rst_input_col", input_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    begin_frame(W1);
    run_pixels(0, 0, nc, nd, ne);
    frame_checks("plain", nc, nd, ne);

    begin_frame(W1);
    run_pixels(1, 0, nc, nd, ne);
    frame_checks("bubble", nc, nd, ne);

    // abort on the first STREAM accept
    begin_frame(W1);
    for (int p = 0; p < 10; p++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data = 8'(p);
    end
    @(negedge clk);
    chk("abort_stream_ready", pix_ready, 1);
    pix_data = 8'd10;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    pix_valid = 1'b0;
    chk("abort_col", col, 0);
    chk("abort_arr_rst", arr_rst, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_ready", pix_ready, 0);
    @(negedge clk);
    chk("abort_arr_rst_end", arr_rst, 0);
    chk("abort_done_after", done, 0);
    begin_frame(W1);
    run_pixels(0, 0, nc, nd, ne);
    frame_checks("post_abort", nc, nd, ne);

    // start pulsed mid-STREAM is ignored
    begin_frame(W1);
    run_pixels(0, 1, nc, nd, ne);
    frame_checks("start_mid", nc, nd, ne);
    chk("start_mid_weights", filter_weights, W1);
    @(negedge clk);
    chk("start_mid_idle", busy, 0);

    // rst mid-FILL
    begin_frame(W2);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix_data = 8'(p);
    end
    @(negedge clk);
    rst = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_pix_ready", pix_ready, 0);
    chk("mrst_arr_rst", arr_rst, 0);
    chk("mrst_load_weight", load_weight, 0);
    chk("mrst_filter_weights", filter_weights, 0);
    chk("mrst_col", col, 0);
    chk("mrst_input_col", input_col, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    begin_frame(W1);
    run_pixels(0, 0, nc, nd, ne);
    frame_checks("post_rst", nc, nd, ne);

    // three starved cycles during FILL
    begin_frame(W1);
    run_pixels(2, 0, nc, nd, ne);
    frame_checks("starve", nc, nd, ne);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Sequences one frame through the 3x3 systolic convolution array: clears it, loads the kernel, then converts a raster pixel stream into 3-pixel vertical columns.
- Sits between the camera/frame-buffer pixel stream and the array. Drives the array's rst, load_weight, col, input_col and filter_weights.
- Holds two image rows internally so each accepted pixel of row y>=2 yields one column {row y-2, row y-1, row y}.

Parameters:
- DATA_WIDTH, 8, pixel/weight width
- IMG_W, 224, pixels per row (>=3)
- IMG_H, 224, rows per frame (>=3)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  synchronous abort, any state
- weights_in  in  9*DATA_WIDTH  kernel; captured on start in IDLE
- pix_valid  in  1  pixel available
- pix_data  in  DATA_WIDTH  raster-order pixel
- pix_ready  out  1  sequencer accepts pixel
- arr_rst  out  1  reset pulse to array
- load_weight  out  1  weight load strobe to array
- filter_weights  out  9*DATA_WIDTH  latched kernel to array
- col  out  1  input_col valid
- input_col  out  3*DATA_WIDTH  [3*DW-1 -: DW]=row y-2, middle=row y-1, LSB=row y
- busy  out  1  not IDLE
- done  out  1  one-cycle end-of-frame pulse

Behaviour:
- All outputs registered. Reset values: pix_ready 0, arr_rst 0, load_weight 0, filter_weights 0, col 0, input_col 0, busy 0, done 0. State IDLE, x=y=0.
- Handshake: pixel accepted on a cycle with pix_valid & pix_ready. pix_ready=1 only in FILL and STREAM.
- States:
  - IDLE: on start, latch weights_in into filter_weights -> CLEAR. Otherwise hold.
  - CLEAR: arr_rst=1 for exactly one cycle -> LOAD.
  - LOAD: load_weight=1 for exactly one cycle -> FILL.
  - FILL (y=0,1): each accept writes the line buffer, col stays 0. At x=IMG_W-1, y=1 -> STREAM.
  - STREAM (y>=2): each accept produces, next cycle, col=1 with input_col={lb_top[x], lb_mid[x], pix}. The line buffer then shifts: lb_top[x]<=lb_mid[x], lb_mid[x]<=pix. Accept of x=IMG_W-1, y=IMG_H-1 -> DONE.
  - DONE: done=1 for one cycle, busy drops the next cycle -> IDLE.
- Column latency: exactly 1 cycle after acceptance. No accept means col=0 that cycle (bubbles allowed; the array only advances on col).
- Counters: x wraps IMG_W-1 -> 0 and increments y. Widths $clog2(IMG_W) and $clog2(IMG_H).
- Column totals per frame: IMG_W*(IMG_H-2) col pulses; W=224 gives 224*222.
- filter_weights is stable from CLEAR until the next start.
- abort, any state: next cycle IDLE, x=y=0, pix_ready=0, col=0, arr_rst pulsed 1 cycle, done not asserted. Line buffer contents are don't-care.
- rst mid-frame: same as the reset values; the next frame is unaffected.
- start while busy: ignored. abort and start together in IDLE: abort wins, stay IDLE.
- pix_valid while pix_ready=0: no accept, counters hold.

Optional Feature:
- Macro CONV_SEQ_PERF_EN.
- Defined: adds output perf_starve (32 bits). It clears on start and increments every FILL/STREAM cycle with pix_valid=0, saturating at all-ones.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package conv_pkg holds:
  - state encoding: IDLE, CLEAR, LOAD, FILL, STREAM, DONE
  - default constants DATA_WIDTH, IMG_W, IMG_H
  - the 3x3 weight packing index function, shared with the array
- One sub-module: conv_line_buffer_2row (parameters DATA_WIDTH, IMG_W).
  - Inputs: x address, write enable, pixel.
  - Outputs: top and mid at that address, read-before-write in the same cycle.

Test Plan:
- IMG_W=5, IMG_H=4, start with weights 1..9, pixels 0..19 always valid:
  - arr_rst the cycle after start, then load_weight; filter_weights = weights.
  - Exactly 10 col pulses. First input_col={0,5,10}, last {9,14,19}.
  - done once; busy low after.
- Same frame with pix_valid toggling every other cycle: identical col sequence, col never set on bubble cycles, count 10.
- abort asserted at first STREAM accept: col=0 next cycle, arr_rst pulse, busy=0, no done. A new frame then yields the full correct 10 columns.
- start pulsed while in STREAM: ignored. filter_weights unchanged and column count unaffected.
- rst held 1 cycle mid-FILL: all outputs return to reset values; the following frame is correct.
- With CONV_SEQ_PERF_EN: 3 invalid cycles injected during FILL -> perf_starve=3 at done.
